// File: rtl/div_int_unsign_check_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_int_unsign_check_if : job request / result bundle of the dividend rebuilder
// Revision: 1.0
// ----------------------------------------------------------------------------
interface div_int_unsign_check_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     qot;
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     rmd;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   dvd;
    logic                 ovf;
    logic                 err;

    modport master (
        output start, qot, dvs, rmd,
        input  busy, done, dvd, ovf, err
    );

    modport slave (
        input  start, qot, dvs, rmd,
        output busy, done, dvd, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/div_int_unsign_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_int_unsign_check : rebuilds dvd = qot*dvs + rmd by shift-add, one bit/clk
// Revision: 1.0
// ----------------------------------------------------------------------------
module div_int_unsign_check #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    div_int_unsign_check_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcd_q, mcd_d;
    logic [WIDTH-1:0]   mpr_q, mpr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_r_q, err_r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] dvd_q, dvd_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] sum;

    // The result is bounded by 2^(2W) - 2^W, so the accumulator never wraps.
    assign sum = acc_q + (mpr_q[0] ? mcd_q : '0);

    always_comb begin
        state_d = state_q;
        mcd_d   = mcd_q;
        mpr_d   = mpr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_r_d = err_r_q;
        done_d  = 1'b0;
        dvd_d   = dvd_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcd_d   = {{WIDTH{1'b0}}, bus.dvs};
                    mpr_d   = bus.qot;
                    acc_d   = {{WIDTH{1'b0}}, bus.rmd};
                    cnt_d   = '0;
                    err_r_d = (bus.dvs == '0) || (bus.rmd >= bus.dvs);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum;
                mcd_d = mcd_q << 1;
                mpr_d = mpr_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    dvd_d   = sum;
                    ovf_d   = |sum[2*WIDTH-1:WIDTH];
                    err_d   = err_r_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mcd_q   <= '0;
            mpr_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_r_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dvd_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcd_q   <= mcd_d;
            mpr_q   <= mpr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_r_q <= err_r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dvd_q   <= dvd_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dvd  = dvd_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;
endmodule
`default_nettype wire

// File: tb/tb_div_int_unsign_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_div_int_unsign_check : vector table, random jobs and handshake/reset corners
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_div_int_unsign_check;
    localparam int WIDTH = 8;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    div_int_unsign_check_if #(.WIDTH(WIDTH)) bus ();

    div_int_unsign_check #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  d;
        logic [7:0]  r;
        logic [15:0] dvd;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int unsigned ref_dvd(input int unsigned q, d, r);
        return q * d + r;
    endfunction

    function automatic bit ref_err(input int unsigned d, r);
        return (d == 0) || (r >= d);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller sits 1 time unit after an edge with the DUT idle.
    task automatic run_job(input logic [7:0] q, d, r, input logic [15:0] ed,
                           input logic eo, ee, input string nm);
        int  k;
        bit  seen;
        bus.qot   = q;
        bus.dvs   = d;
        bus.rmd   = r;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.qot   = 8'($urandom);
        bus.dvs   = 8'($urandom);
        bus.rmd   = 8'($urandom);
        check({nm, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        seen = 1'b0;
        k    = 1;
        while (!seen && k <= 20) begin
            step();
            if (bus.done) seen = 1'b1;
            else k++;
        end
        check({nm, " latency"}, 32'(k), 32'(WIDTH));
        check({nm, " dvd"}, 32'(bus.dvd), 32'(ed));
        check({nm, " ovf"}, 32'(bus.ovf), 32'(eo));
        check({nm, " err"}, 32'(bus.err), 32'(ee));
        step();
        check({nm, " done_clear"}, 32'(bus.done), 32'd0);
        check({nm, " busy_clear"}, 32'(bus.busy), 32'd0);
        check({nm, " dvd_hold"}, 32'(bus.dvd), 32'(ed));
    endtask

    initial begin
        int unsigned rq, rd, rr, rv;
        logic [7:0]  ops_q [30];
        logic [7:0]  ops_d [30];
        logic [7:0]  ops_r [30];
        int          ndone;
        int          last_done;
        bit          any_done;

        n_tests = 0;
        n_fail  = 0;

        tbl[0] = '{8'd10,  8'd10,  8'd0,   16'd100,   1'b0, 1'b0};
        tbl[1] = '{8'd3,   8'd20,  8'd7,   16'd67,    1'b0, 1'b0};
        tbl[2] = '{8'd10,  8'd9,   8'd0,   16'd90,    1'b0, 1'b0};
        tbl[3] = '{8'd7,   8'd10,  8'd5,   16'd75,    1'b0, 1'b0};
        tbl[4] = '{8'd5,   8'd3,   8'd1,   16'd16,    1'b0, 1'b0};
        tbl[5] = '{8'd51,  8'd5,   8'd0,   16'd255,   1'b0, 1'b0};
        tbl[6] = '{8'd255, 8'd255, 8'd254, 16'hFEFF,  1'b1, 1'b0};
        tbl[7] = '{8'd9,   8'd0,   8'd17,  16'd17,    1'b0, 1'b1};
        tbl[8] = '{8'd5,   8'd3,   8'd3,   16'd18,    1'b0, 1'b1};

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.qot   = '0;
        bus.dvs   = '0;
        bus.rmd   = '0;
        step();
        step();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset dvd",  32'(bus.dvd),  32'd0);
        check("reset ovf",  32'(bus.ovf),  32'd0);
        check("reset err",  32'(bus.err),  32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++)
            run_job(tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].dvd, tbl[i].ovf, tbl[i].err,
                    $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rq = $urandom_range(255);
            rd = (i % 5 == 0) ? 0 : $urandom_range(255);
            rr = (i % 3 == 0) ? $urandom_range(255) : ((rd > 0) ? $urandom_range(rd - 1) : 0);
            rv = ref_dvd(rq, rd, rr);
            run_job(8'(rq), 8'(rd), 8'(rr), 16'(rv), rv > 255, ref_err(rd, rr),
                    $sformatf("rnd%0d", i));
        end

        // Start held high with operands changing every cycle.
        bus.start = 1'b1;
        ndone     = 0;
        last_done = -1;
        for (int c = 0; c < 30; c++) begin
            ops_q[c] = 8'($urandom);
            ops_d[c] = 8'($urandom);
            ops_r[c] = 8'($urandom);
            bus.qot  = ops_q[c];
            bus.dvs  = ops_d[c];
            bus.rmd  = ops_r[c];
            step();
            if (bus.done) begin
                ndone++;
                if (last_done >= 0)
                    check("hold spacing", 32'(c - last_done), 32'(WIDTH + 2));
                last_done = c;
                if (c >= WIDTH) begin
                    rv = ref_dvd(ops_q[c-WIDTH], ops_d[c-WIDTH], ops_r[c-WIDTH]);
                    check($sformatf("hold dvd c%0d", c), 32'(bus.dvd), rv);
                    check($sformatf("hold err c%0d", c), 32'(bus.err),
                          32'(ref_err(ops_d[c-WIDTH], ops_r[c-WIDTH])));
                end
            end
        end
        check("hold done count", 32'(ndone), 32'd3);
        bus.start = 1'b0;
        for (int c = 0; c < 12; c++) step();

        // Stray start pulses inside CALC and DONE must not launch a job.
        bus.qot = 8'd10; bus.dvs = 8'd10; bus.rmd = 8'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            bus.start = (k == 3 || k == WIDTH);
            bus.qot   = 8'd200;
            step();
        end
        check("stray done", 32'(bus.done), 32'd1);
        check("stray dvd", 32'(bus.dvd), 32'd100);
        bus.start = 1'b0;
        step();
        any_done = 1'b0;
        check("stray busy_idle", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 12; k++) begin
            if (bus.done || bus.busy) any_done = 1'b1;
            step();
        end
        check("stray no_extra_job", 32'(any_done), 32'd0);

        // Reset on the 4th CALC edge discards the job.
        bus.qot = 8'd200; bus.dvs = 8'd100; bus.rmd = 8'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        reset_n = 1'b0;
        step();
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst dvd",  32'(bus.dvd),  32'd0);
        check("midrst ovf",  32'(bus.ovf),  32'd0);
        check("midrst err",  32'(bus.err),  32'd0);
        reset_n  = 1'b1;
        any_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.done) any_done = 1'b1;
        end
        check("midrst no_done", 32'(any_done), 32'd0);

        // Reset together with start: not accepted.
        reset_n = 1'b0; bus.start = 1'b1;
        step();
        reset_n = 1'b1; bus.start = 1'b0;
        any_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.busy || bus.done) any_done = 1'b1;
            step();
        end
        check("rst_start not_accepted", 32'(any_done), 32'd0);

        run_job(8'd12, 8'd13, 8'd4, 16'd160, 1'b0, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/div_int_unsign_check.md
# div_int_unsign_check

Sequential reconstruction unit that runs the unsigned integer divider in reverse: from a quotient, divisor and remainder it rebuilds the dividend as dvd = qot*dvs + rmd. It uses a shift-add datapath, one multiplier bit per clock. It sits beside the combinational `division` block, so the divider's result can be self-checked in-system or in the bench. It also flags divider results that are structurally illegal (zero divisor, remainder not less than divisor).

## Interface

- WIDTH, 8, operand width of qot/dvs/rmd; dividend output is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a reconstruction; accepted only in IDLE.
- qot  input  WIDTH  quotient, sampled on the accepting edge.
- dvs  input  WIDTH  divisor, sampled on the accepting edge.
- rmd  input  WIDTH  remainder, sampled on the accepting edge.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; dvd, ovf and err are valid and newly updated.
- dvd  output  2*WIDTH  reconstructed dividend; holds until the next completion.
- ovf  output  1  high when dvd[2*WIDTH-1:WIDTH] != 0, i.e. the dividend does not fit in WIDTH bits.
- err  output  1  high when dvs == 0 or rmd >= dvs for the completed job.

## Operation

- Reset: when reset_n = 0 at an edge, the state goes to IDLE and all internal registers clear. busy, done, dvd, ovf and err are all 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start = 1, load the internal registers:
    - mcd ← zero-extended dvs (2*WIDTH bits)
    - mpr ← qot
    - acc ← zero-extended rmd
    - cnt ← 0
    - err_r ← (dvs == 0) || (rmd >= dvs)
  - Go to CALC.
  - With start = 0, stay in IDLE.
- CALC, each edge:
  - If mpr[0], acc ← acc + mcd.
  - Then mcd ← mcd << 1, mpr ← mpr >> 1, cnt ← cnt + 1.
  - On the edge where cnt == WIDTH-1 (the WIDTH-th iteration), the final sum is written directly into dvd. On the same edge:
    - ovf ← upper half of that sum non-zero
    - err ← err_r
    - done ← 1
    - state → DONE
- DONE:
  - Next edge: done ← 0, state → IDLE.
  - dvd, ovf and err keep their values.
- Arithmetic:
  - All arithmetic is unsigned, with a 2*WIDTH-bit accumulator.
  - The maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so the accumulator can never wrap and needs no carry-out.
  - cnt is ceil(log2(WIDTH)) bits wide and fixes the iteration count at exactly WIDTH, independent of operand values. There is no early termination.
- err does not alter the computation: dvd is still qot*dvs + rmd. With dvs == 0, dvd = rmd.
- start while busy (CALC or DONE) is ignored. Operand inputs are not sampled outside the accepting edge and may change freely.
- Reset mid-operation: the in-flight job is discarded with no done pulse, and outputs return to 0 as specified for reset.
- If reset_n = 0 and start = 1 on the same edge, reset wins and the job is not accepted.

## Timing

- Accepting edge E (IDLE, start = 1): busy = 1 from E onward.
- Iterations occur on edges E+1 … E+WIDTH.
- done = 1 in the cycle after edge E+WIDTH, for exactly one cycle; dvd, ovf and err are updated on that same edge.
- Edge E+WIDTH+1 returns to IDLE, so busy = 0 after it.
- The earliest next accepting edge is E+WIDTH+2.
- Throughput: one job per WIDTH+2 cycles.
- Latency from accepting edge to done-high cycle: WIDTH cycles (8 for WIDTH = 8).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use WIDTH = 8.

- Exact division: qot=10, dvs=10, rmd=0, start pulse → done 8 cycles after accept; dvd=100, ovf=0, err=0.
- Divider-style sweep: (3,20,7), (10,9,0), (7,10,5), (5,3,1), (51,5,0) → dvd = 67, 90, 75, 16, 255 respectively; all ovf=0 and err=0. busy drops one cycle after each done; each start is issued on the first IDLE cycle.
- Maximum operands: qot=255, dvs=255, rmd=254 → dvd=65279 (0xFEFF), ovf=1, err=0; no accumulator wrap.
- Illegal inputs:
  - qot=9, dvs=0, rmd=17 → dvd=17, err=1.
  - qot=5, dvs=3, rmd=3 → dvd=18, err=1, ovf=0.
- Handshake:
  - Hold start high continuously and change operands during CALC → exactly one done per WIDTH+2 cycles. Each result uses only the operands sampled on its accepting edge.
  - A start pulse inside CALC or DONE produces no extra job.
- Reset: assert reset_n=0 at the 4th CALC edge of a job → next cycle busy=0, done=0, dvd=0, ovf=0, err=0, and no done pulse ever appears for that job. Reset held together with start=1 → job not accepted.
